imsic_msi_receiver: RTL and testbench

AXI4-Lite write-channel responder that terminates MSI writes from the system bus and converts each valid `seteipnum_le` write into a single set-pending request for one IMSIC interrupt file. It sits between the bus fabric and the interrupt-file register logic. It is the slave-side counterpart of the bus write master used to inject MSIs in the IMSIC test environment. Each file occupies one 4 KiB page starting at `BASE_ADDR`.

---
 rtl/imsic_msi_receiver.sv | 145 ++++++++++++++
 tb/tb_imsic_msi_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imsic_msi_receiver.sv
// AXI4-Lite write responder that turns seteipnum_le MSI writes into set-pending requests
// for one IMSIC interrupt file; anything malformed is answered OKAY and dropped.
module imsic_msi_receiver #(
  parameter int unsigned NR_SRC         = 30,
  parameter int unsigned NR_INTP_FILES  = 2,
  parameter logic [63:0] BASE_ADDR      = 64'h2400_0000,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned FILE_LEN       = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1,
  parameter int unsigned NR_SRC_LEN     = $clog2(NR_SRC)
) (
  input  logic                        i_clk,
  input  logic                        ni_rst,
  input  logic                        i_awvalid,
  output logic                        o_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [AXI_ID_WIDTH-1:0]     i_awid,
  input  logic                        i_wvalid,
  output logic                        o_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_wstrb,
  output logic                        o_bvalid,
  input  logic                        i_bready,
  output logic [1:0]                  o_bresp,
  output logic [AXI_ID_WIDTH-1:0]     o_bid,
  output logic                        o_msi_valid,
  input  logic                        i_msi_ready,
  output logic [FILE_LEN-1:0]         o_msi_file,
  output logic [NR_SRC_LEN-1:0]       o_msi_id,
  output logic                        o_drop
);

  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;
  localparam int unsigned PageW = AXI_ADDR_WIDTH - 12;
  localparam logic [PageW-1:0] NrFilesPage = PageW'(NR_INTP_FILES);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StHaveAw   = 3'd1;
  localparam logic [2:0] StHaveW    = 3'd2;
  localparam logic [2:0] StDispatch = 3'd3;
  localparam logic [2:0] StResp     = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXI_ID_WIDTH-1:0]   aw_id_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [StrbW-1:0]          w_strb_q;
  logic [AXI_ID_WIDTH-1:0]   bid_q;
  logic [FILE_LEN-1:0]       msi_file_q;
  logic [NR_SRC_LEN-1:0]     msi_id_q;
  logic                      drop_q;

  logic aw_hs, w_hs, complete, accept;
  logic [AXI_ADDR_WIDTH-1:0] eff_addr, off;
  logic [AXI_ID_WIDTH-1:0]   eff_id;
  logic [AXI_DATA_WIDTH-1:0] eff_data;
  logic [StrbW-1:0]          eff_strb;
  logic [31:0]               lane_data;
  logic [3:0]                lane_strb;

  assign o_awready = (state_q == StIdle) || (state_q == StHaveW);
  assign o_wready  = (state_q == StIdle) || (state_q == StHaveAw);
  assign aw_hs     = i_awvalid & o_awready;
  assign w_hs      = i_wvalid & o_wready;

  // On the completing cycle one half of the write comes from the holding register.
  assign eff_addr = (state_q == StHaveAw) ? aw_addr_q : i_awaddr;
  assign eff_id   = (state_q == StHaveAw) ? aw_id_q   : i_awid;
  assign eff_data = (state_q == StHaveW)  ? w_data_q  : i_wdata;
  assign eff_strb = (state_q == StHaveW)  ? w_strb_q  : i_wstrb;
  assign off      = eff_addr - BASE_ADDR[AXI_ADDR_WIDTH-1:0];

  if (AXI_DATA_WIDTH == 64) begin : g_lane64
    assign lane_data = eff_addr[2] ? eff_data[63:32] : eff_data[31:0];
    assign lane_strb = eff_addr[2] ? eff_strb[7:4]   : eff_strb[3:0];
  end else begin : g_lane32
    assign lane_data = eff_data[31:0];
    assign lane_strb = eff_strb[3:0];
  end

  assign accept = (eff_addr >= BASE_ADDR[AXI_ADDR_WIDTH-1:0]) &&
                  (off[AXI_ADDR_WIDTH-1:12] < NrFilesPage) &&
                  (off[11:0] == 12'h000) &&
                  (lane_strb == 4'hF) &&
                  (lane_data >= 32'd1) &&
                  (lane_data <= 32'(NR_SRC - 1));

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      StIdle: begin
        if (aw_hs && w_hs) complete = 1'b1;
        else if (aw_hs)    state_d  = StHaveAw;
        else if (w_hs)     state_d  = StHaveW;
      end
      StHaveAw:   if (w_hs) complete = 1'b1;
      StHaveW:    if (aw_hs) complete = 1'b1;
      StDispatch: if (i_msi_ready) state_d = StResp;
      StResp:     if (i_bready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (complete) state_d = accept ? StDispatch : StResp;
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_q    <= StIdle;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bid_q      <= '0;
      msi_file_q <= '0;
      msi_id_q   <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= complete & ~accept;
      if (aw_hs) begin
        aw_addr_q <= i_awaddr;
        aw_id_q   <= i_awid;
      end
      if (w_hs) begin
        w_data_q <= i_wdata;
        w_strb_q <= i_wstrb;
      end
      if (complete) bid_q <= eff_id;
      if (complete && accept) begin
        msi_file_q <= off[12 +: FILE_LEN];
        msi_id_q   <= lane_data[NR_SRC_LEN-1:0];
      end
    end
  end

  assign o_msi_valid = (state_q == StDispatch);
  assign o_msi_file  = msi_file_q;
  assign o_msi_id    = msi_id_q;
  assign o_bvalid    = (state_q == StResp);
  assign o_bresp     = 2'b00;
  assign o_bid       = bid_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_imsic_msi_receiver.sv
// Directed bench for imsic_msi_receiver: a transaction-level decode model plus a per-cycle monitor.
module tb_imsic_msi_receiver;

  localparam logic [63:0] Base   = 64'h2400_0000;
  localparam int          NrSrc  = 30;
  localparam int          NFiles = 2;

  logic        i_clk, ni_rst;
  logic        i_awvalid, o_awready;
  logic [63:0] i_awaddr;
  logic [3:0]  i_awid;
  logic        i_wvalid, o_wready;
  logic [63:0] i_wdata;
  logic [7:0]  i_wstrb;
  logic        o_bvalid, i_bready;
  logic [1:0]  o_bresp;
  logic [3:0]  o_bid;
  logic        o_msi_valid, i_msi_ready;
  logic [0:0]  o_msi_file;
  logic [4:0]  o_msi_id;
  logic        o_drop;

  int total = 0;
  int bad   = 0;

  bit          mon_en = 0;
  bit          exp_acc;
  int          exp_file, exp_id;
  logic [3:0]  exp_bid;

  imsic_msi_receiver dut (
    .i_clk       (i_clk),
    .ni_rst      (ni_rst),
    .i_awvalid   (i_awvalid),
    .o_awready   (o_awready),
    .i_awaddr    (i_awaddr),
    .i_awid      (i_awid),
    .i_wvalid    (i_wvalid),
    .o_wready    (o_wready),
    .i_wdata     (i_wdata),
    .i_wstrb     (i_wstrb),
    .o_bvalid    (o_bvalid),
    .i_bready    (i_bready),
    .o_bresp     (o_bresp),
    .o_bid       (o_bid),
    .o_msi_valid (o_msi_valid),
    .i_msi_ready (i_msi_ready),
    .o_msi_file  (o_msi_file),
    .o_msi_id    (o_msi_id),
    .o_drop      (o_drop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // What a write should do, straight from the address map and identity rules.
  function automatic void model(input logic [63:0] addr, input logic [63:0] data,
                                input logic [7:0] strb, output bit acc, output int file,
                                output int id);
    logic [63:0] off;
    logic [31:0] d;
    logic [3:0]  s;
    off  = addr - Base;
    d    = addr[2] ? data[63:32] : data[31:0];
    s    = addr[2] ? strb[7:4] : strb[3:0];
    acc  = (addr >= Base) && ((off / 4096) < NFiles) && ((off % 4096) == 0) &&
           (s == 4'hF) && (d >= 1) && (d <= NrSrc - 1);
    file = int'(off / 4096);
    id   = int'(d);
  endfunction

  always @(negedge i_clk) begin
    if (ni_rst && mon_en) begin
      if (o_msi_valid) begin
        chk("mon_msi_is_accept", 64'(exp_acc), 64'd1);
        chk("mon_msi_file", 64'(o_msi_file), 64'(exp_file));
        chk("mon_msi_id", 64'(o_msi_id), 64'(exp_id));
      end
      if (o_bvalid) begin
        chk("mon_bresp", 64'(o_bresp), 64'd0);
        chk("mon_bid", 64'(o_bid), 64'(exp_bid));
      end
      if (o_drop) begin
        chk("mon_drop_is_reject", 64'(exp_acc), 64'd0);
        chk("mon_drop_with_b", 64'(o_bvalid), 64'd1);
      end
      if (o_msi_valid || o_bvalid) chk("mon_busy_readies", {o_awready, o_wready}, 64'd0);
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // lead > 0: W goes lead cycles before AW; lead < 0: AW goes first; 0: same cycle.
  task automatic write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                       input logic [3:0] id, input int lead, input int msi_hold,
                       input int b_hold);
    bit acc;
    int f, m;
    logic [4:0] id0;
    logic       file0;
    model(addr, data, strb, acc, f, m);
    exp_acc = acc; exp_file = f; exp_id = m; exp_bid = id;
    i_msi_ready = (msi_hold == 0);
    i_bready    = (b_hold == 0);
    i_awaddr = addr; i_awid = id; i_wdata = data; i_wstrb = strb;
    if (lead > 0) begin
      i_wvalid = 1'b1; tick; i_wvalid = 1'b0;
      chk("have_w_wready", 64'(o_wready), 64'd0);
      chk("have_w_awready", 64'(o_awready), 64'd1);
      repeat (lead - 1) tick;
      i_awvalid = 1'b1; tick; i_awvalid = 1'b0;
    end else if (lead < 0) begin
      i_awvalid = 1'b1; tick; i_awvalid = 1'b0;
      chk("have_aw_awready", 64'(o_awready), 64'd0);
      chk("have_aw_wready", 64'(o_wready), 64'd1);
      repeat (-lead - 1) tick;
      i_wvalid = 1'b1; tick; i_wvalid = 1'b0;
    end else begin
      i_awvalid = 1'b1; i_wvalid = 1'b1; tick;
      i_awvalid = 1'b0; i_wvalid = 1'b0;
    end
    chk("n1_msi_valid", 64'(o_msi_valid), 64'(acc));
    chk("n1_drop", 64'(o_drop), 64'(!acc));
    chk("n1_bvalid", 64'(o_bvalid), 64'(!acc));
    if (acc) begin
      id0 = o_msi_id; file0 = o_msi_file;
      for (int i = 0; i < msi_hold; i++) begin
        tick;
        chk("msi_hold_valid", 64'(o_msi_valid), 64'd1);
        chk("msi_hold_id", 64'(o_msi_id), 64'(id0));
        chk("msi_hold_file", 64'(o_msi_file), 64'(file0));
      end
      i_msi_ready = 1'b1;
      tick;
      chk("m1_bvalid", 64'(o_bvalid), 64'd1);
      chk("m1_msi_valid", 64'(o_msi_valid), 64'd0);
    end
    for (int i = 0; i < b_hold; i++) begin
      tick;
      chk("b_hold_bvalid", 64'(o_bvalid), 64'd1);
      chk("drop_one_cycle", 64'(o_drop), 64'd0);
    end
    i_bready = 1'b1;
    tick;
    chk("after_b_bvalid", 64'(o_bvalid), 64'd0);
    chk("after_b_drop", 64'(o_drop), 64'd0);
    chk("after_b_readies", {o_awready, o_wready}, 64'h3);
  endtask

  initial begin
    bit acc;
    int f, m;
    ni_rst = 1'b0;
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_awaddr = '0; i_awid = '0;
    i_wdata = '0; i_wstrb = '0; i_bready = 1'b1; i_msi_ready = 1'b1;

    // Pin the model against hand-decoded vectors.
    model(64'h2400_1000, 64'd3, 8'h0F, acc, f, m);
    chk("pin_model_acc", 64'(acc), 64'd1);
    chk("pin_model_file", 64'(f), 64'd1);
    chk("pin_model_id", 64'(m), 64'd3);
    model(64'h23FF_F000, 64'd5, 8'h0F, acc, f, m);
    chk("pin_model_below", 64'(acc), 64'd0);
    model(64'h2400_0000, 64'd30, 8'h0F, acc, f, m);
    chk("pin_model_id30", 64'(acc), 64'd0);

    #12;
    chk("rst_awready", 64'(o_awready), 64'd1);
    chk("rst_wready", 64'(o_wready), 64'd1);
    chk("rst_bvalid", 64'(o_bvalid), 64'd0);
    chk("rst_bresp", 64'(o_bresp), 64'd0);
    chk("rst_bid", 64'(o_bid), 64'd0);
    chk("rst_msi_valid", 64'(o_msi_valid), 64'd0);
    chk("rst_msi_file", 64'(o_msi_file), 64'd0);
    chk("rst_msi_id", 64'(o_msi_id), 64'd0);
    chk("rst_drop", 64'(o_drop), 64'd0);
    ni_rst = 1'b1;
    mon_en = 1'b1;
    tick;

    write(64'h2400_0000, 64'h5, 8'h0F, 4'h3, 0, 0, 0);
    chk("lit_t1_id", 64'(o_msi_id), 64'd5);
    chk("lit_t1_bid", 64'(o_bid), 64'h3);
    write(64'h2400_1000, 64'h3, 8'h0F, 4'h7, 2, 0, 0);
    chk("lit_t2_file", 64'(o_msi_file), 64'd1);
    chk("lit_t2_id", 64'(o_msi_id), 64'd3);
    write(64'h2400_0000, 64'h0, 8'h0F, 4'h1, 0, 0, 0);
    write(64'h2400_0000, 64'd30, 8'h0F, 4'h2, 0, 0, 0);
    write(64'h2400_0000, 64'h5, 8'h03, 4'h4, 0, 0, 2);
    write(64'h2400_2000, 64'h5, 8'h0F, 4'h5, 0, 0, 0);
    write(64'h2400_0004, 64'h5_0000_0000, 8'hF0, 4'h6, -1, 0, 0);
    write(64'h23FF_F000, 64'h5, 8'h0F, 4'h8, 1, 0, 0);
    write(64'h2400_0000, 64'hFFFF_FFFF_0000_0004, 8'hFF, 4'h9, 0, 0, 0);
    chk("lit_upper_ignored_id", 64'(o_msi_id), 64'd4);
    write(64'h2400_1000, 64'd29, 8'h0F, 4'hA, -2, 5, 3);
    chk("lit_held_id", 64'(o_msi_id), 64'd29);
    chk("lit_held_bid", 64'(o_bid), 64'hA);

    // Reset while a request sits in DISPATCH.
    exp_acc = 1'b1; exp_file = 0; exp_id = 7; exp_bid = 4'hB;
    i_msi_ready = 1'b0;
    i_awaddr = Base; i_awid = 4'hB; i_wdata = 64'd7; i_wstrb = 8'h0F;
    i_awvalid = 1'b1; i_wvalid = 1'b1; tick;
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    chk("rst_pre_msi_valid", 64'(o_msi_valid), 64'd1);
    #2 ni_rst = 1'b0;
    #1;
    chk("arst_msi_valid", 64'(o_msi_valid), 64'd0);
    chk("arst_msi_id", 64'(o_msi_id), 64'd0);
    chk("arst_readies", {o_awready, o_wready}, 64'h3);
    chk("arst_bvalid", 64'(o_bvalid), 64'd0);
    #8 ni_rst = 1'b1;
    i_msi_ready = 1'b1; i_bready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("post_rst_no_b", 64'(o_bvalid), 64'd0);
      chk("post_rst_no_msi", 64'(o_msi_valid), 64'd0);
      chk("post_rst_readies", {o_awready, o_wready}, 64'h3);
    end

    write(64'h2400_1000, 64'd1, 8'h0F, 4'hC, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
